// File: rtl/pldata_pkg.sv
// Shared types and elaboration helpers for the pldata capture engine.
package pldata_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Selector width leaves room for one index beyond the real sources (test generator slot).
    function automatic int sel_w(input int num_src);
        return $clog2(num_src + 1);
    endfunction

    function automatic int byte_step(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/pldata_addr_gen.sv
// Word counter, wrapping byte-address pointer and terminal-count compare for one frame.
module pldata_addr_gen
    import pldata_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_in,
    input  logic              advance_in,
    input  logic [ADDR_W-3:0] len_in,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-2:0] cnt_o,
    output logic              last_o
);

    localparam int CNT_W = ADDR_W - 1;
    localparam int LEN_W = ADDR_W - 2;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  len_full_s;

    // A zero length means the full 2^LEN_W word depth, which needs the extra count bit.
    always_comb begin
        if (len_in == {LEN_W{1'b0}}) begin
            len_full_s = {1'b1, {LEN_W{1'b0}}};
        end else begin
            len_full_s = {1'b0, len_in};
        end
        last_o = ((cnt_q + CNT_W'(1)) == len_full_s);
    end

    // Next counter and pointer values; the pointer wraps naturally modulo 2^ADDR_W.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (clear_in) begin
            cnt_d  = {CNT_W{1'b0}};
            addr_d = ADDR_W'(BASE_ADDR);
        end else if (advance_in) begin
            cnt_d  = cnt_q + CNT_W'(1);
            addr_d = addr_q + ADDR_W'(STEP);
        end else begin
            cnt_d  = cnt_q;
            addr_d = addr_q;
        end
    end

    // Counter and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            addr_q <= ADDR_W'(BASE_ADDR);
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/pldata_capture_mux.sv
// N-source framed capture into the pldata BRAM port with latched select, length, done and abort.
// Optional internal pattern source on selector value NUM_SRC when PLDATA_TESTGEN_EN is defined.
module pldata_capture_mux
    import pldata_pkg::*;
#(
    parameter int  NUM_SRC   = 4,
    parameter int  DATA_W    = 32,
    parameter int  ADDR_W    = 10,
    parameter int  BASE_ADDR = 0,
    localparam int SEL_W     = sel_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          src_sel_in,
    input  logic                      arm_in,
    input  logic                      abort_in,
    input  logic [ADDR_W-3:0]         frame_len_in,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
    input  logic [NUM_SRC-1:0]        src_valid_in,
    output logic                      ram_wr_o,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic [DATA_W-1:0]         ram_din_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ADDR_W-2:0]         word_cnt_o
);

    localparam int STEP  = byte_step(DATA_W);
    localparam int LEN_W = ADDR_W - 2;

    state_e              state_q;
    state_e              state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_d;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    logic                ram_wr_q;
    logic                ram_wr_d;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [ADDR_W-1:0]   ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q;
    logic [DATA_W-1:0]   ram_din_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;

    logic                sel_valid_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                clear_s;
    logic                advance_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic [ADDR_W-2:0]   cnt_s;
    logic                last_s;

    pldata_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .STEP      (STEP)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear_in   (clear_s),
        .advance_in (advance_s),
        .len_in     (len_q),
        .addr_o     (next_addr_s),
        .cnt_o      (cnt_s),
        .last_o     (last_s)
    );

    // Source mux on the latched selector; out-of-range indices never produce a strobe.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_valid_s = src_valid_in[i];
                sel_data_s  = src_data_in[i*DATA_W +: DATA_W];
            end else begin
            end
        end
`ifdef PLDATA_TESTGEN_EN
        if (sel_q == SEL_W'(NUM_SRC)) begin
            sel_valid_s = 1'b1;
            sel_data_s  = DATA_W'(cnt_s);
        end else begin
        end
`endif
    end

    // Next-state logic; abort has priority over arm and over any new write.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        clear_s   = 1'b0;
        advance_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (arm_in) begin
                    sel_d   = src_sel_in;
                    len_d   = frame_len_in;
                    clear_s = 1'b1;
                    state_d = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (sel_valid_s) begin
                    advance_s = 1'b1;
                    if (last_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = CAPTURE;
                    end
                end else begin
                    state_d = CAPTURE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs; busy spans the done pulse so it falls the cycle after.
    always_comb begin
        ram_wr_d = advance_s;
        if (advance_s) begin
            ram_addr_d = next_addr_s;
            ram_din_d  = sel_data_s;
        end else begin
            ram_addr_d = ram_addr_q;
            ram_din_d  = ram_din_q;
        end
        busy_d = (state_d != IDLE) || (state_q == DONE);
        done_d = (state_q == DONE);
    end

    // FSM state and latched frame configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= {SEL_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
        end
    end

    // Registered RAM port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr_q   <= 1'b0;
            ram_addr_q <= ADDR_W'(BASE_ADDR);
            ram_din_q  <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_wr_o   = ram_wr_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_din_o  = ram_din_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign word_cnt_o = cnt_s;

endmodule

// File: tb/tb_pldata_capture_mux.sv
// Scoreboard bench for pldata_capture_mux (NUM_SRC=4, DATA_W=32, ADDR_W=6, BASE_ADDR=32).
module tb_pldata_capture_mux;

    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 6;
    localparam int BASE_ADDR = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [2:0]                src_sel_in;
    logic                      arm_in;
    logic                      abort_in;
    logic [ADDR_W-3:0]         frame_len_in;
    logic [NUM_SRC*DATA_W-1:0] src_data_in;
    logic [NUM_SRC-1:0]        src_valid_in;
    logic                      ram_wr_o;
    logic [ADDR_W-1:0]         ram_addr_o;
    logic [DATA_W-1:0]         ram_din_o;
    logic                      busy_o;
    logic                      done_o;
    logic [ADDR_W-2:0]         word_cnt_o;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                checks    = 0;
    int                failures  = 0;
    int                done_cnt  = 0;
    logic [ADDR_W-1:0] model_addr;

    always #5 clk = ~clk;

    pldata_capture_mux #(
        .NUM_SRC   (NUM_SRC),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_sel_in   (src_sel_in),
        .arm_in       (arm_in),
        .abort_in     (abort_in),
        .frame_len_in (frame_len_in),
        .src_data_in  (src_data_in),
        .src_valid_in (src_valid_in),
        .ram_wr_o     (ram_wr_o),
        .ram_addr_o   (ram_addr_o),
        .ram_din_o    (ram_din_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .word_cnt_o   (word_cnt_o)
    );

    // Output monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
        if (ram_wr_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", ram_addr_o, ram_din_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (ram_addr_o !== mon_e.addr || ram_din_o !== mon_e.data) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             ram_addr_o, ram_din_o, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] data);
        exp_q.push_back({model_addr, data});
        model_addr = model_addr + 6'd4;
    endtask

    task automatic do_arm(input logic [2:0] sel, input logic [ADDR_W-3:0] len);
        src_sel_in   = sel;
        frame_len_in = len;
        arm_in       = 1'b1;
        tick();
        arm_in       = 1'b0;
        model_addr   = 6'(BASE_ADDR);
    endtask

    task automatic wait_done(input int budget, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (done_o === 1'b1) seen = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arm_in = 1'b0; abort_in = 1'b0; src_sel_in = 3'd0;
        frame_len_in = 4'd0; src_data_in = '0; src_valid_in = 4'd0;
        tick(); tick();
        checks++; if (ram_wr_o !== 1'b0) begin failures++; $display("FAIL reset_wr got=%0b exp=0", ram_wr_o); end
        checks++; if (ram_addr_o !== 6'd32) begin failures++; $display("FAIL reset_addr got=%0d exp=32", ram_addr_o); end
        checks++; if (ram_din_o !== 32'd0) begin failures++; $display("FAIL reset_din got=%h exp=0", ram_din_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done_o); end
        checks++; if (word_cnt_o !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        do_arm(3'd2, 4'd8);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%0b exp=1", busy_o); end
        for (int n = 0; n < 8; n++) begin
            src_valid_in = 4'b0100;
            src_data_in[2*DATA_W +: DATA_W] = 32'hA0 + 32'(n);
            push_exp(32'hA0 + 32'(n));
            tick();
        end
        src_valid_in = 4'd0;
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%0b exp=0", done_o); end
        tick();
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", done_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%0b exp=1", busy_o); end
        checks++; if (word_cnt_o !== 5'd8) begin failures++; $display("FAIL basic_cnt got=%0d exp=8", word_cnt_o); end
        tick();
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL basic_after got done=%0b busy=%0b exp 0 0", done_o, busy_o); end
        checks++; if (word_cnt_o !== 5'd8) begin failures++; $display("FAIL basic_cnt_hold got=%0d exp=8", word_cnt_o); end
        checks++; if (exp_q.size() != 0 || done_cnt - d0 != 1) begin failures++; $display("FAIL basic_tail got pending=%0d dones=%0d exp 0 1", exp_q.size(), done_cnt - d0); end
    endtask

    task automatic test_ignore_others();
        bit seen; int waited; int n = 0;
        do_arm(3'd2, 4'd6);
        for (int c = 0; c < 24 && n < 6; c++) begin
            src_valid_in = {~c[0], (c % 3 != 1), c[0], 1'b1};
            for (int i = 0; i < NUM_SRC; i++) src_data_in[i*DATA_W +: DATA_W] = {8'(i), 24'(c)};
            if (src_valid_in[2]) begin
                push_exp({8'd2, 24'(c)});
                n++;
            end
            tick();
        end
        src_valid_in = 4'd0;
        wait_done(6, seen, waited);
        checks++; if (!seen) begin failures++; $display("FAIL gapped_done got=0 exp=1"); end
        checks++; if (word_cnt_o !== 5'd6) begin failures++; $display("FAIL gapped_cnt got=%0d exp=6", word_cnt_o); end
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL gapped_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_full_wrap();
        bit seen; int waited;
        do_arm(3'd0, 4'd0);
        for (int n = 0; n < 16; n++) begin
            src_valid_in = 4'b0001;
            src_data_in[0 +: DATA_W] = $urandom;
            push_exp(src_data_in[0 +: DATA_W]);
            tick();
        end
        src_valid_in = 4'd0;
        wait_done(4, seen, waited);
        checks++; if (!seen) begin failures++; $display("FAIL wrap_done got=0 exp=1"); end
        checks++; if (word_cnt_o !== 5'd16) begin failures++; $display("FAIL wrap_cnt got=%0d exp=16", word_cnt_o); end
        checks++; if (ram_addr_o !== 6'd28) begin failures++; $display("FAIL wrap_last_addr got=%0d exp=28", ram_addr_o); end
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_abort();
        bit seen; int waited; int d0 = done_cnt;
        do_arm(3'd1, 4'd10);
        for (int n = 0; n < 3; n++) begin
            src_valid_in = 4'b0010;
            src_data_in[1*DATA_W +: DATA_W] = $urandom;
            push_exp(src_data_in[1*DATA_W +: DATA_W]);
            tick();
        end
        src_valid_in = 4'd0;
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL abort_flags got busy=%0b done=%0b exp 0 0", busy_o, done_o); end
        checks++; if (word_cnt_o !== 5'd3) begin failures++; $display("FAIL abort_cnt got=%0d exp=3", word_cnt_o); end
        do_arm(3'd1, 4'd2);
        checks++; if (busy_o !== 1'b1 || word_cnt_o !== 5'd0) begin failures++; $display("FAIL rearm got busy=%0b cnt=%0d exp 1 0", busy_o, word_cnt_o); end
        for (int n = 0; n < 2; n++) begin
            src_valid_in = 4'b0010;
            src_data_in[1*DATA_W +: DATA_W] = 32'h5500 + 32'(n);
            push_exp(32'h5500 + 32'(n));
            tick();
        end
        src_valid_in = 4'd0;
        wait_done(4, seen, waited);
        tick();
        checks++; if (!seen || done_cnt - d0 != 1) begin failures++; $display("FAIL abort_dones got=%0d exp=1", done_cnt - d0); end
        // Abort and arm together in IDLE must not start a frame.
        src_sel_in = 3'd1; frame_len_in = 4'd2; arm_in = 1'b1; abort_in = 1'b1;
        tick();
        arm_in = 1'b0; abort_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            src_valid_in = 4'b0010;
            tick();
        end
        src_valid_in = 4'd0;
        tick();
        checks++; if (busy_o !== 1'b0 || word_cnt_o !== 5'd2) begin failures++; $display("FAIL abort_arm got busy=%0b cnt=%0d exp 0 2", busy_o, word_cnt_o); end
    endtask

    task automatic test_arm_ignore();
        bit seen; int waited;
        do_arm(3'd3, 4'd5);
        for (int c = 0; c < 5; c++) begin
            src_valid_in = 4'b1001;
            src_data_in[3*DATA_W +: DATA_W] = 32'h300 + 32'(c);
            src_data_in[0 +: DATA_W] = 32'hBAD;
            arm_in = (c == 1);
            src_sel_in = 3'd0;
            frame_len_in = 4'd2;
            push_exp(32'h300 + 32'(c));
            tick();
        end
        arm_in = 1'b0;
        src_valid_in = 4'd0;
        wait_done(4, seen, waited);
        checks++; if (!seen) begin failures++; $display("FAIL arm_ignore_done got=0 exp=1"); end
        checks++; if (word_cnt_o !== 5'd5) begin failures++; $display("FAIL arm_ignore_cnt got=%0d exp=5", word_cnt_o); end
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL arm_ignore_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit seen; int waited;
        do_arm(3'd0, 4'd3);
        for (int n = 0; n < 3; n++) begin
            src_valid_in = 4'b0001;
            src_data_in[0 +: DATA_W] = 32'h1000 + 32'(n);
            push_exp(32'h1000 + 32'(n));
            tick();
        end
        src_valid_in = 4'd0;
        tick();
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b exp=1", done_o); end
        do_arm(3'd1, 4'd2);
        checks++; if (busy_o !== 1'b1 || word_cnt_o !== 5'd0 || done_o !== 1'b0) begin failures++; $display("FAIL b2b_rearm got busy=%0b cnt=%0d done=%0b exp 1 0 0", busy_o, word_cnt_o, done_o); end
        for (int n = 0; n < 2; n++) begin
            src_valid_in = 4'b0010;
            src_data_in[1*DATA_W +: DATA_W] = 32'h2000 + 32'(n);
            push_exp(32'h2000 + 32'(n));
            tick();
        end
        src_valid_in = 4'd0;
        wait_done(4, seen, waited);
        checks++; if (!seen || word_cnt_o !== 5'd2) begin failures++; $display("FAIL b2b_second got seen=%0b cnt=%0d exp 1 2", seen, word_cnt_o); end
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        do_arm(3'd2, 4'd8);
        for (int n = 0; n < 2; n++) begin
            src_valid_in = 4'b0100;
            src_data_in[2*DATA_W +: DATA_W] = 32'h7700 + 32'(n);
            push_exp(32'h7700 + 32'(n));
            tick();
        end
        src_valid_in = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0 || ram_wr_o !== 1'b0 || word_cnt_o !== 5'd0 || ram_addr_o !== 6'd32) begin
            failures++; $display("FAIL reset_mid got busy=%0b wr=%0b cnt=%0d addr=%0d exp 0 0 0 32", busy_o, ram_wr_o, word_cnt_o, ram_addr_o);
        end
        tick(); tick(); tick();
        checks++; if (done_cnt != d0 || exp_q.size() != 0) begin failures++; $display("FAIL reset_mid_tail got dones=%0d pending=%0d exp 0 0", done_cnt - d0, exp_q.size()); end
    endtask

    task automatic test_testgen();
        bit seen; int waited; int d0 = done_cnt;
`ifdef PLDATA_TESTGEN_EN
        do_arm(3'd4, 4'd5);
        for (int n = 0; n < 5; n++) push_exp(32'(n));
        wait_done(10, seen, waited);
        checks++; if (!seen || waited != 6) begin failures++; $display("FAIL testgen_timing got seen=%0b waited=%0d exp 1 6", seen, waited); end
        checks++; if (word_cnt_o !== 5'd5) begin failures++; $display("FAIL testgen_cnt got=%0d exp=5", word_cnt_o); end
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL testgen_pending got=%0d exp=0", exp_q.size()); end
`else
        do_arm(3'd4, 4'd2);
        for (int n = 0; n < 6; n++) begin
            src_valid_in = 4'hF;
            src_data_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL oor_busy got=%0b exp=1", busy_o); end
        end
        src_valid_in = 4'd0;
        checks++; if (word_cnt_o !== 5'd0) begin failures++; $display("FAIL oor_cnt got=%0d exp=0", word_cnt_o); end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL oor_abort got=%0b exp=0", busy_o); end
        tick();
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL oor_done got=%0d exp=0", done_cnt - d0); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_others();
        test_full_wrap();
        test_abort();
        test_arm_ignore();
        test_back_to_back();
        test_reset_mid();
        test_testgen();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
